rtc_read_sequencer: RTL

- Upstream neighbour of the RTC parameter register stage.
- On a start request, runs one read sweep over the multiplexed address/data bus of the external RTC (Intel-mode: CS, RD, WR, A/D), reading nine registers: seconds, minutes, hours, day, month, year, timer-seconds, timer-minutes, timer-hours.
- Drives the 6-bit sequence address `addr` that the downstream stage decodes. Each captured byte is on its `*_l` output and stable before `addr` reaches that value's downstream sample point (10, 15, …, 50).

---
 rtl/rtc_pkg.sv | 60 ++++++
 rtl/rtc_step_timer.sv | 33 +++
 rtl/rtc_read_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC read sequencer: default RTC register
// addresses, sweep geometry, FSM encoding and slot decode helpers.
package rtc_pkg;

    // Default RTC register addresses (Intel-mode multiplexed bus)
    localparam logic [7:0] REG_S_DEF  = 8'h21;
    localparam logic [7:0] REG_M_DEF  = 8'h22;
    localparam logic [7:0] REG_H_DEF  = 8'h23;
    localparam logic [7:0] REG_D_DEF  = 8'h24;
    localparam logic [7:0] REG_ME_DEF = 8'h25;
    localparam logic [7:0] REG_A_DEF  = 8'h26;
    localparam logic [7:0] REG_ST_DEF = 8'h41;
    localparam logic [7:0] REG_MT_DEF = 8'h42;
    localparam logic [7:0] REG_HT_DEF = 8'h43;

    // Sweep geometry: slot k covers addr SLOT_BASE+SLOT_LEN*k .. +SLOT_LEN-1
    localparam int SLOT_BASE = 5;
    localparam int SLOT_LEN  = 5;
    localparam int NUM_SLOTS = 9;
    localparam int LAST_ADDR = 54;

    // Downstream stage samples slot k at SAMPLE_FIRST + SLOT_LEN*k (10..50)
    localparam int SAMPLE_FIRST = 10;
    localparam int SAMPLE_LAST  = 50;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rtc_state_t;

    typedef struct packed {
        logic       valid;  // addr lies inside a register slot
        logic [3:0] k;      // slot index 0..8
        logic [2:0] j;      // offset within slot 0..4
    } slot_pos_t;

    // Map a sequence address onto (slot, offset); lead-in and tail are invalid.
    function automatic slot_pos_t slot_decode(input logic [5:0] a);
        slot_pos_t p;
        int        off;
        off = int'(a) - SLOT_BASE;
        if (off >= 0 && off < SLOT_LEN * NUM_SLOTS) begin
            p.valid = 1'b1;
            p.k     = 4'(off / SLOT_LEN);
            p.j     = 3'(off % SLOT_LEN);
        end else begin
            p.valid = 1'b0;
            p.k     = 4'd0;
            p.j     = 3'd0;
        end
        return p;
    endfunction

    // Downstream sample address for slot k.
    function automatic logic [5:0] sample_addr(input logic [3:0] k);
        return 6'(SAMPLE_FIRST + SLOT_LEN * int'(k));
    endfunction

endpackage

// File: rtl/rtc_step_timer.sv
// Step timer: counts 0..STEP_CYC-1 while enabled and flags the last clock
// of each step so the sequencer can advance addr exactly on that edge.
module rtc_step_timer #(
    parameter int STEP_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step_end
);

    localparam logic [7:0] LAST_CNT = 8'(STEP_CYC - 1);

    logic [7:0] cnt_r;

    // Last clock of the current step (decoded straight from the counter)
    assign step_end = en && (cnt_r == LAST_CNT);

    // Step counter: cleared outside RUN, wraps to 0 at the end of each step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (en) begin
            cnt_r <= step_end ? 8'd0 : cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/rtc_read_sequencer.sv
// RTC read sequencer: one start request runs a sweep of nine register reads
// over the multiplexed RTC bus, stepping addr 0..54 for the downstream stage.
// All bus strobes are registered from the next-step decode so they change
// only on step boundaries and line up exactly with addr.
module rtc_read_sequencer
    import rtc_pkg::*;
#(
    parameter int         STEP_CYC = 4,
    parameter logic [7:0] REG_S    = REG_S_DEF,
    parameter logic [7:0] REG_M    = REG_M_DEF,
    parameter logic [7:0] REG_H    = REG_H_DEF,
    parameter logic [7:0] REG_D    = REG_D_DEF,
    parameter logic [7:0] REG_ME   = REG_ME_DEF,
    parameter logic [7:0] REG_A    = REG_A_DEF,
    parameter logic [7:0] REG_ST   = REG_ST_DEF,
    parameter logic [7:0] REG_MT   = REG_MT_DEF,
    parameter logic [7:0] REG_HT   = REG_HT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [5:0] addr,
    output logic [7:0] s_l,
    output logic [7:0] m_l,
    output logic [7:0] h_l,
    output logic [7:0] d_l,
    output logic [7:0] me_l,
    output logic [7:0] a_l,
    output logic [7:0] st_l,
    output logic [7:0] mt_l,
    output logic [7:0] ht_l,
    output logic       busy,
    output logic       done
);

    localparam logic [5:0] LAST_ADDR_V = 6'(LAST_ADDR);

    rtc_state_t state_r;
    rtc_state_t state_nxt_s;
    logic [5:0] addr_r;
    logic [5:0] addr_nxt_s;
    logic       rst_seen_r;
    logic       step_end_s;
    logic       tmr_en_s;
    logic       tmr_clr_s;
    slot_pos_t  cur_pos_s;
    slot_pos_t  nxt_pos_s;
    logic [7:0] reg_sel_s;
    logic       capture_s;

    logic [7:0] ad_out_nxt_s, ad_out_r;
    logic       ad_oe_nxt_s,  ad_oe_r;
    logic       cs_n_nxt_s,   cs_n_r;
    logic       rd_n_nxt_s,   rd_n_r;
    logic       wr_n_nxt_s,   wr_n_r;
    logic       a_d_nxt_s,    a_d_r;
    logic       busy_r;
    logic       done_r;
    logic [7:0] cap_r [NUM_SLOTS];

    assign tmr_en_s  = (state_r == ST_RUN);
    assign tmr_clr_s = (state_r != ST_RUN);

    rtc_step_timer #(
        .STEP_CYC (STEP_CYC)
    ) u_step_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (tmr_en_s),
        .clr      (tmr_clr_s),
        .step_end (step_end_s)
    );

    // Blocks start on the first clock after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_seen_r <= 1'b0;
        end else begin
            rst_seen_r <= 1'b1;
        end
    end

    // FSM state, sequence address and registered bus/status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            addr_r   <= 6'd0;
            ad_out_r <= 8'h00;
            ad_oe_r  <= 1'b0;
            cs_n_r   <= 1'b1;
            rd_n_r   <= 1'b1;
            wr_n_r   <= 1'b1;
            a_d_r    <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            addr_r   <= addr_nxt_s;
            ad_out_r <= ad_out_nxt_s;
            ad_oe_r  <= ad_oe_nxt_s;
            cs_n_r   <= cs_n_nxt_s;
            rd_n_r   <= rd_n_nxt_s;
            wr_n_r   <= wr_n_nxt_s;
            a_d_r    <= a_d_nxt_s;
            busy_r   <= (state_nxt_s == ST_RUN);
            done_r   <= (state_nxt_s == ST_DONE);
        end
    end

    // Next state and next addr; start is honoured only from IDLE
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        case (state_r)
            ST_IDLE: begin
                addr_nxt_s = 6'd0;
                if (start && rst_seen_r) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (step_end_s && (addr_r == LAST_ADDR_V)) begin
                    state_nxt_s = ST_DONE;
                    addr_nxt_s  = 6'd0;
                end else if (step_end_s) begin
                    state_nxt_s = ST_RUN;
                    addr_nxt_s  = addr_r + 6'd1;
                end else begin
                    state_nxt_s = ST_RUN;
                    addr_nxt_s  = addr_r;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                addr_nxt_s  = 6'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                addr_nxt_s  = 6'd0;
            end
        endcase
    end

    // RTC register address for the slot about to be entered
    always_comb begin
        nxt_pos_s = slot_decode(addr_nxt_s);
        case (nxt_pos_s.k)
            4'd0:    reg_sel_s = REG_S;
            4'd1:    reg_sel_s = REG_M;
            4'd2:    reg_sel_s = REG_H;
            4'd3:    reg_sel_s = REG_D;
            4'd4:    reg_sel_s = REG_ME;
            4'd5:    reg_sel_s = REG_A;
            4'd6:    reg_sel_s = REG_ST;
            4'd7:    reg_sel_s = REG_MT;
            4'd8:    reg_sel_s = REG_HT;
            default: reg_sel_s = 8'h00;
        endcase
    end

    // Bus phase for the next step: address write, turnaround, read, release
    always_comb begin
        ad_out_nxt_s = 8'h00;
        ad_oe_nxt_s  = 1'b0;
        cs_n_nxt_s   = 1'b1;
        rd_n_nxt_s   = 1'b1;
        wr_n_nxt_s   = 1'b1;
        a_d_nxt_s    = 1'b1;
        if ((state_nxt_s == ST_RUN) && nxt_pos_s.valid) begin
            case (nxt_pos_s.j)
                3'd0: begin
                    cs_n_nxt_s   = 1'b0;
                    a_d_nxt_s    = 1'b0;
                    wr_n_nxt_s   = 1'b0;
                    ad_oe_nxt_s  = 1'b1;
                    ad_out_nxt_s = reg_sel_s;
                end
                3'd2, 3'd3: begin
                    cs_n_nxt_s = 1'b0;
                    rd_n_nxt_s = 1'b0;
                end
                default: begin
                    cs_n_nxt_s = 1'b1;
                    rd_n_nxt_s = 1'b1;
                end
            endcase
        end else begin
            ad_oe_nxt_s = 1'b0;
        end
    end

    // Capture strobe: last clock of the second read step of a slot
    always_comb begin
        cur_pos_s = slot_decode(addr_r);
        if ((state_r == ST_RUN) && step_end_s && cur_pos_s.valid &&
            (cur_pos_s.j == 3'd3)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Capture registers; held until the next sweep overwrites them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                cap_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (capture_s && (cur_pos_s.k == 4'(i))) begin
                    cap_r[i] <= ad_in;
                end else begin
                    cap_r[i] <= cap_r[i];
                end
            end
        end
    end

    assign addr   = addr_r;
    assign ad_out = ad_out_r;
    assign ad_oe  = ad_oe_r;
    assign cs_n   = cs_n_r;
    assign rd_n   = rd_n_r;
    assign wr_n   = wr_n_r;
    assign a_d    = a_d_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign s_l    = cap_r[0];
    assign m_l    = cap_r[1];
    assign h_l    = cap_r[2];
    assign d_l    = cap_r[3];
    assign me_l   = cap_r[4];
    assign a_l    = cap_r[5];
    assign st_l   = cap_r[6];
    assign mt_l   = cap_r[7];
    assign ht_l   = cap_r[8];

endmodule
